rx_core: RTL and testbench

//   UART receiver, 8N1, LSB first; the stage that consumes the serial line driven by tx_core.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync2.sv | 33 +++
 rtl/rx_core.sv | 174 +++++++++++++++++
 tb/tb_rx_core.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit and receive cores.
//   - uart_state_t : frame FSM encodings (IDLE/START/DATA/STOP/RECOVER)
//   - OVERSAMPLE_DEF / DATA_BITS_DEF : default line parameters (16x, 8 bits)
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_RECOVER = 3'd4
   } uart_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
//   Two-flop synchronizer for an asynchronous single-bit input. Resets to 1 so
//   an idle-high serial line does not look like a start bit coming out of reset.
//   Ports:
//     i_clk    destination clock
//     i_rst_n  synchronous, active-low reset
//     i_d      asynchronous input
//     o_q      synchronized output (two i_clk edges of latency)
// -----------------------------------------------------------------------------
module uart_sync2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule : uart_sync2

// File: rtl/rx_core.sv
// -----------------------------------------------------------------------------
// rx_core
//   UART receiver, 8N1 by default, LSB first. Oversamples the line, validates
//   the start bit at its midpoint, samples each data bit and the stop bit at
//   the end of a full bit period measured from that midpoint, and presents the
//   byte in a valid/ready holding register.
//   Ports:
//     rx_clk     oversample clock (OVERSAMPLE x baud)
//     reset_n    synchronous, active-low reset
//     rx         asynchronous serial input, idle high
//     rx_data    received byte, stable while rx_valid=1
//     rx_valid   holding register full
//     rx_ready   consumer accepts (transfer on rx_valid & rx_ready)
//     rx_done    1-cycle pulse when a good frame is loaded
//     frame_err  1-cycle pulse when the stop bit is sampled low
//     overrun    1-cycle pulse when a good frame finds the holding reg full
// -----------------------------------------------------------------------------
module rx_core
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                 rx_clk,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_done,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE/2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   uart_state_t          r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_idx;
   logic [DATA_BITS-1:0] r_shreg;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_done;
   logic                 r_ferr;
   logic                 r_ovr;

   logic                 w_rx_s;
   logic [DATA_BITS:0]   w_cat;
   logic [DATA_BITS-1:0] w_shift;
   logic                 w_cnt_last;
   logic                 w_can_load;

   uart_sync2 u_sync (
      .i_clk   (rx_clk),
      .i_rst_n (reset_n),
      .i_d     (rx),
      .o_q     (w_rx_s)
   );

   // New bit enters at the MSB and everything moves one place toward the LSB,
   // so after DATA_BITS samples the first (LSB) bit sits at bit 0.
   assign w_cat      = {w_rx_s, r_shreg};
   assign w_shift    = w_cat[DATA_BITS:1];
   assign w_cnt_last = (r_cnt == CNT_LAST);
   // Holding register is free if empty or being drained on this same edge.
   assign w_can_load = !r_valid || rx_ready;

   always_ff @(posedge rx_clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shreg <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;

         // Consumer handshake; a load in the STOP branch below overrides this.
         if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (!w_rx_s) begin
                  r_state <= ST_START;
               end
            end

            ST_START: begin
               if (r_cnt == CNT_MID) begin
                  r_cnt <= '0;
                  r_idx <= '0;
                  // Line back high at mid start bit: treat as a glitch.
                  r_state <= w_rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            ST_DATA: begin
               if (w_cnt_last) begin
                  r_cnt   <= '0;
                  r_shreg <= w_shift;
                  if (r_idx == IDX_LAST) begin
                     r_state <= ST_STOP;
                  end else begin
                     r_idx <= r_idx + IDX_ONE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            ST_STOP: begin
               if (w_cnt_last) begin
                  r_cnt <= '0;
                  if (w_rx_s) begin
                     if (w_can_load) begin
                        r_data  <= r_shreg;
                        r_valid <= 1'b1;
                        r_done  <= 1'b1;
                     end else begin
                        r_ovr <= 1'b1;
                     end
                     // Leave at mid stop bit so a back-to-back start edge is seen.
                     r_state <= ST_IDLE;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= ST_RECOVER;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            ST_RECOVER: begin
               // Hold off until the line returns high so a long break only
               // reports a single framing error.
               r_cnt <= '0;
               if (w_rx_s) begin
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign rx_done   = r_done;
   assign frame_err = r_ferr;
   assign overrun   = r_ovr;

endmodule : rx_core

// File: tb/tb_rx_core.sv
module tb_rx_core;

   localparam int OS  = 16;
   localparam int LAT = 155;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, rx_done, frame_err, overrun;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int frame_start = 0;

   int n_done = 0, n_ferr = 0, n_ovr = 0, n_vld = 0, n_both = 0;
   int last_done_cyc = 0;
   logic [7:0] last_data = 8'h00;

   rx_core #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .rx_clk    (clk),
      .reset_n   (reset_n),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_done) begin
         n_done <= n_done + 1;
         last_data <= rx_data;
         last_done_cyc <= cyc;
      end
      if (frame_err) n_ferr <= n_ferr + 1;
      if (overrun)   n_ovr  <= n_ovr + 1;
      if (rx_valid)  n_vld  <= n_vld + 1;
      if ((rx_done && frame_err) || (rx_done && overrun)) n_both <= n_both + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One 8N1 frame, each bit held for OS edges, then 'idle' high cycles.
   task automatic send_byte(input logic [7:0] d, input logic stop_b, input int idle);
      logic [9:0] fr;
      fr = {stop_b, d, 1'b0};
      frame_start = cyc;
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         repeat (OS) @(posedge clk);
         #1;
      end
      rx = 1'b1;
      repeat (idle) @(posedge clk);
      #1;
   endtask

   int d0, f0, o0, v0;
   logic [7:0] rb;

   initial begin
      // ---------------- reset ----------------
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(rx_valid), 0);
      chk("rst_data",  32'(rx_data), 0);
      chk("rst_done",  32'(rx_done), 0);
      chk("rst_ferr",  32'(frame_err), 0);
      chk("rst_ovr",   32'(overrun), 0);
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // ---------------- 0xA5, ready=1, latency ----------------
      d0 = n_done; v0 = n_vld;
      send_byte(8'hA5, 1'b1, 16);
      chk("a5_done_cnt", 32'(n_done - d0), 1);
      chk("a5_data",     32'(last_data), 32'hA5);
      chk("a5_latency",  32'(last_done_cyc - frame_start), LAT);
      chk("a5_vld_cyc",  32'(n_vld - v0), 1);
      chk("a5_ferr",     32'(n_ferr), 0);

      // ---------------- start-bit glitch ----------------
      d0 = n_done; f0 = n_ferr; v0 = n_vld;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("glitch_done", 32'(n_done - d0), 0);
      chk("glitch_ferr", 32'(n_ferr - f0), 0);
      chk("glitch_vld",  32'(n_vld - v0), 0);
      chk("glitch_idle", 32'(dut.r_state), 32'(uart_pkg::ST_IDLE));
      send_byte(8'h96, 1'b1, 8);
      chk("post_glitch_data", 32'(last_data), 32'h96);
      chk("post_glitch_lat",  32'(last_done_cyc - frame_start), LAT);

      // ---------------- framing error then recovery ----------------
      d0 = n_done; f0 = n_ferr; v0 = n_vld;
      send_byte(8'h3C, 1'b0, 16);
      chk("ferr_pulse", 32'(n_ferr - f0), 1);
      chk("ferr_done",  32'(n_done - d0), 0);
      chk("ferr_vld",   32'(n_vld - v0), 0);
      send_byte(8'h3C, 1'b1, 8);
      chk("after_ferr_data", 32'(last_data), 32'h3C);
      chk("after_ferr_done", 32'(n_done - d0), 1);

      // ---------------- held-low break -> one frame_err ----------------
      d0 = n_done; f0 = n_ferr;
      rx = 1'b0;
      repeat (400) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("break_ferr", 32'(n_ferr - f0), 1);
      chk("break_done", 32'(n_done - d0), 0);

      // ---------------- overrun ----------------
      rx_ready = 1'b0;
      d0 = n_done; o0 = n_ovr;
      send_byte(8'h11, 1'b1, 8);
      chk("ovr_first_vld",  32'(rx_valid), 1);
      chk("ovr_first_data", 32'(rx_data), 32'h11);
      send_byte(8'h22, 1'b1, 8);
      chk("ovr_pulse", 32'(n_ovr - o0), 1);
      chk("ovr_held",  32'(rx_data), 32'h11);
      chk("ovr_done",  32'(n_done - d0), 1);

      // load and consume on the same edge: valid stays high with new byte
      o0 = n_ovr;
      fork
         send_byte(8'h44, 1'b1, 8);
         begin
            repeat (LAT - 1) @(posedge clk);
            #2;
            rx_ready = 1'b1;
            @(posedge clk);
            #2;
            rx_ready = 1'b0;
         end
      join
      chk("same_edge_vld",  32'(rx_valid), 1);
      chk("same_edge_data", 32'(rx_data), 32'h44);
      chk("same_edge_ovr",  32'(n_ovr - o0), 0);

      // ---------------- reset during DATA bit 3 ----------------
      d0 = n_done; f0 = n_ferr;
      fork
         send_byte(8'hFF, 1'b1, 16);
         begin
            repeat (67) @(posedge clk);
            #2;
            reset_n = 1'b0;
            @(posedge clk);
            #1;
            chk("midrst_valid", 32'(rx_valid), 0);
            chk("midrst_data",  32'(rx_data), 0);
            chk("midrst_done",  32'(rx_done), 0);
            chk("midrst_ferr",  32'(frame_err), 0);
            chk("midrst_ovr",   32'(overrun), 0);
            reset_n = 1'b1;
         end
      join
      chk("midrst_no_frame", 32'(n_done - d0), 0);
      chk("midrst_no_ferr",  32'(n_ferr - f0), 0);
      rx_ready = 1'b1;
      send_byte(8'h5A, 1'b1, 8);
      chk("midrst_next_data", 32'(last_data), 32'h5A);
      chk("midrst_next_lat",  32'(last_done_cyc - frame_start), LAT);

      // ---------------- back-to-back random frames ----------------
      f0 = n_ferr; o0 = n_ovr;
      for (int k = 0; k < 20; k++) begin
         rb = 8'($urandom_range(0, 255));
         d0 = n_done;
         send_byte(rb, 1'b1, 0);
         chk($sformatf("b2b_data_%0d", k), 32'(last_data), 32'(rb));
         chk($sformatf("b2b_done_%0d", k), 32'(n_done - d0), 1);
      end
      repeat (10) @(posedge clk);
      #1;
      chk("b2b_ferr",  32'(n_ferr - f0), 0);
      chk("b2b_ovr",   32'(n_ovr - o0), 0);
      chk("b2b_valid", 32'(rx_valid), 0);
      chk("no_overlap", 32'(n_both), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule : tb_rx_core
